// File: rtl/fifo_burst_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_burst_reader_pkg : shared types and defaults for the burst reader|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package fifo_burst_reader_pkg;

    localparam int C_WIDTH_DEFAULT     = 32;
    localparam int C_LEN_WIDTH_DEFAULT = 8;
    localparam int C_STATE_WIDTH       = 2;

    typedef enum logic [C_STATE_WIDTH-1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_burst_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_burst_reader_if : control, FIFO read port and output stream      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface fifo_burst_reader_if
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH     = C_WIDTH_DEFAULT,
    parameter int LEN_WIDTH = C_LEN_WIDTH_DEFAULT
) ();

    logic                 start;
    logic [LEN_WIDTH-1:0] burst_length;
    logic                 busy;
    logic                 done;
    logic                 fifo_read_enable;
    logic [WIDTH-1:0]     fifo_read_data;
    logic                 fifo_empty;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_last;

    // The burst reader itself
    modport slave (
        input  start, burst_length, fifo_read_data, fifo_empty, out_ready,
        output busy, done, fifo_read_enable, out_valid, out_data, out_last
    );

    // The environment: requester, FIFO and downstream sink
    modport master (
        output start, burst_length, fifo_read_data, fifo_empty, out_ready,
        input  busy, done, fifo_read_enable, out_valid, out_data, out_last
    );

endinterface
`default_nettype wire

// File: rtl/stream_skid_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_skid_buffer : output register plus one-entry skid register     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module stream_skid_buffer #(
    parameter int WIDTH = 33
) (
    input  wire              clk,
    input  wire              reset_n,
    input  wire              i_valid,
    input  wire  [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    input  wire              i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_skid_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             w_out_fire;

    assign w_out_fire = r_out_valid && i_ready;
    // Upstream ready comes straight from a flop, so no path from i_ready.
    assign o_ready    = !r_skid_valid;
    assign o_valid    = r_out_valid;
    assign o_data     = r_out_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else begin
            if (i_valid && !r_skid_valid) begin
                if (!r_out_valid || w_out_fire) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= i_data;
                end else begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= i_data;
                end
            end else if (w_out_fire) begin
                if (r_skid_valid) begin
                    r_out_data   <= r_skid_data;
                    r_skid_valid <= 1'b0;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fifo_burst_reader : pops a counted burst from a show-ahead FIFO       |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int WIDTH     = C_WIDTH_DEFAULT,
    parameter int LEN_WIDTH = C_LEN_WIDTH_DEFAULT
) (
    input wire                 clk,
    input wire                 reset_n,
    fifo_burst_reader_if.slave bus
);

    state_t               r_state;
    state_t               w_state_next;
    logic [LEN_WIDTH-1:0] r_remaining;
    logic                 r_done;
    logic                 w_busy;
    logic                 w_pop;
    logic                 w_pop_last;
    logic                 w_skid_ready;
    logic                 w_out_valid;
    logic [WIDTH:0]       w_out_payload;
    logic                 w_last_fire;
    logic                 w_start_idle;

    assign w_start_idle = (r_state == ST_IDLE) && bus.start;
    assign w_pop_last   = (r_remaining == LEN_WIDTH'(1));
    assign w_last_fire  = w_out_valid && bus.out_ready && w_out_payload[WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (bus.start && (bus.burst_length != '0)) w_state_next = ST_READ;
            ST_READ:  if (w_pop && w_pop_last)                   w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_last_fire)                           w_state_next = ST_IDLE;
            default:                                             w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != ST_IDLE);
        w_pop  = (r_state == ST_READ) && !bus.fifo_empty
                 && (r_remaining != '0) && w_skid_ready;
    end

    // A zero-length request completes on its own without touching the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_remaining <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= (w_start_idle && (bus.burst_length == '0))
                      || ((r_state == ST_DRAIN) && w_last_fire);
            if (w_start_idle) begin
                r_remaining <= bus.burst_length;
            end else if (w_pop) begin
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
        end
    end

    stream_skid_buffer #(
        .WIDTH (WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (w_pop),
        .i_data  ({w_pop_last, bus.fifo_read_data}),
        .o_ready (w_skid_ready),
        .o_valid (w_out_valid),
        .i_ready (bus.out_ready),
        .o_data  (w_out_payload)
    );

    assign bus.busy             = w_busy;
    assign bus.done             = r_done;
    assign bus.fifo_read_enable = w_pop;
    assign bus.out_valid        = w_out_valid;
    assign bus.out_data         = w_out_payload[WIDTH-1:0];
    assign bus.out_last         = w_out_payload[WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fifo_burst_reader : random and directed bench with queue model     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_fifo_burst_reader;

    localparam int WIDTH     = 32;
    localparam int LEN_WIDTH = 8;
    localparam int NWORDS    = 8192;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             last;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    fifo_burst_reader_if #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

    fifo_burst_reader #(.WIDTH(WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // FIFO contents are stream[pop_cnt .. push_cnt-1]; bursts claim stream words in order.
    logic [WIDTH-1:0] stream [NWORDS];
    int   push_cnt, pop_cnt, burst_ptr;
    exp_t exp_q[$];
    bit   busy_m, done_m;
    int   gap_cnt, gap_trigger, burst_pops;
    int   ready_mode;
    bit   tog, fill_on;
    int   tests, fails, cyc, done_cnt;
    int   first_pop_cyc, last_pop_cyc;
    logic prev_ov, prev_or, prev_pop, prev_ol;
    logic [WIDTH-1:0] prev_od, prev_pop_data;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic cycle(input logic st, input logic [LEN_WIDTH-1:0] len);
        logic ren, ov, ol, rdy, b0, done_next;
        logic [WIDTH-1:0] od, pdata;
        exp_t e;
        @(negedge clk);
        cyc++;
        check_eq("done", bus.done, done_m);
        check_eq("busy", bus.busy, busy_m);
        if (bus.done) done_cnt++;
        if (prev_ov && !prev_or) begin
            check_eq("hold_valid", bus.out_valid, 1'b1);
            check_eq("hold_data", bus.out_data, prev_od);
            check_eq("hold_last", bus.out_last, prev_ol);
        end
        if (prev_pop && (!prev_ov || prev_or)) begin
            check_eq("lat_valid", bus.out_valid, 1'b1);
            check_eq("lat_data", bus.out_data, prev_pop_data);
        end
        if (fill_on && push_cnt < NWORDS && $urandom_range(3) != 0) push_cnt++;
        case (ready_mode)
            0:       rdy = 1'b1;
            1:       begin tog = !tog; rdy = tog; end
            2:       rdy = 1'($urandom_range(1));
            default: rdy = 1'b0;
        endcase
        bus.out_ready      = rdy;
        bus.fifo_empty     = (pop_cnt == push_cnt) || (gap_cnt > 0);
        bus.fifo_read_data = (pop_cnt < push_cnt) ? stream[pop_cnt] : '0;
        bus.start          = st;
        bus.burst_length   = len;
        #1;
        ren   = bus.fifo_read_enable;
        ov    = bus.out_valid;
        od    = bus.out_data;
        ol    = bus.out_last;
        pdata = stream[pop_cnt];
        check_eq("ren_empty", ren && bus.fifo_empty, 1'b0);
        check_eq("ren_idle", ren && !busy_m, 1'b0);
        @(posedge clk);
        b0        = busy_m;
        done_next = 1'b0;
        if (gap_cnt > 0) gap_cnt--;
        if (ren) begin
            pop_cnt++;
            burst_pops++;
            if (burst_pops == gap_trigger) gap_cnt = 5;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        if (ov && rdy) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_word", ov, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check_eq("data", od, e.data);
                check_eq("last", ol, e.last);
                if (e.last) begin
                    busy_m    = 1'b0;
                    done_next = 1'b1;
                end
            end
        end
        if (st && !b0) begin
            if (len == '0) begin
                done_next = 1'b1;
            end else begin
                busy_m     = 1'b1;
                burst_pops = 0;
                for (int i = 0; i < int'(len); i++)
                    exp_q.push_back('{data: stream[burst_ptr + i], last: (i == int'(len) - 1)});
                burst_ptr += int'(len);
            end
        end
        done_m        = done_next;
        prev_ov       = ov;
        prev_or       = rdy;
        prev_od       = od;
        prev_ol       = ol;
        prev_pop      = ren;
        prev_pop_data = pdata;
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while ((busy_m || done_m) && n < budget) begin
            cycle(1'b0, '0);
            n++;
        end
        if (busy_m || done_m) check_eq("idle_timeout", {busy_m, done_m}, 2'b00);
        check_eq("pop_total", pop_cnt, burst_ptr);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_done", bus.done, 1'b0);
        check_eq("rst_ren", bus.fifo_read_enable, 1'b0);
        check_eq("rst_valid", bus.out_valid, 1'b0);
        check_eq("rst_data", bus.out_data, '0);
        check_eq("rst_last", bus.out_last, 1'b0);
        busy_m    = 1'b0;
        done_m    = 1'b0;
        exp_q.delete();
        burst_ptr = pop_cnt;
        gap_cnt   = 0;
        prev_ov   = 1'b0;
        prev_pop  = 1'b0;
        bus.start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_no_pop", bus.fifo_read_enable, 1'b0);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        int d0, n;
        tests = 0; fails = 0; cyc = 0; done_cnt = 0;
        push_cnt = 0; pop_cnt = 0; burst_ptr = 0;
        busy_m = 0; done_m = 0; gap_cnt = 0; gap_trigger = 0; burst_pops = 0;
        ready_mode = 0; tog = 0; fill_on = 0;
        prev_ov = 0; prev_or = 0; prev_pop = 0; prev_ol = 0; prev_od = '0; prev_pop_data = '0;
        for (int i = 0; i < NWORDS; i++) stream[i] = $urandom;
        for (int i = 0; i < 4; i++) stream[i] = 32'hA0 + i;
        bus.start = 0; bus.burst_length = '0; bus.out_ready = 0;
        bus.fifo_empty = 1; bus.fifo_read_data = '0;

        repeat (3) @(negedge clk);
        check_eq("init_busy", bus.busy, 1'b0);
        check_eq("init_done", bus.done, 1'b0);
        check_eq("init_ren", bus.fifo_read_enable, 1'b0);
        check_eq("init_valid", bus.out_valid, 1'b0);
        check_eq("init_data", bus.out_data, '0);
        check_eq("init_last", bus.out_last, 1'b0);
        reset_n = 1'b1;

        // Preloaded A0..A3, always ready: four back-to-back pops.
        push_cnt = 4; first_pop_cyc = -1; ready_mode = 0;
        cycle(1'b1, 8'd4);
        run_idle(50);
        check_eq("ren_run", last_pop_cyc - first_pop_cyc + 1, 4);

        // Alternating ready.
        push_cnt += 8; ready_mode = 1; tog = 0;
        cycle(1'b1, 8'd8);
        run_idle(100);

        // FIFO empty gap after the second pop.
        push_cnt += 6; ready_mode = 0; gap_trigger = 2;
        cycle(1'b1, 8'd6);
        run_idle(100);
        gap_trigger = 0;

        // Zero length, then starts while busy.
        d0 = done_cnt;
        cycle(1'b1, 8'd0);
        cycle(1'b0, 8'd0);
        cycle(1'b0, 8'd0);
        check_eq("zero_len_done", done_cnt - d0, 1);
        check_eq("zero_len_pops", pop_cnt, burst_ptr);
        push_cnt += 12; ready_mode = 2;
        cycle(1'b1, 8'd5);
        cycle(1'b1, 8'd3);
        cycle(1'b1, 8'd7);
        run_idle(200);

        // Back-to-back bursts on the done cycle.
        push_cnt += 5; ready_mode = 0; d0 = done_cnt;
        cycle(1'b1, 8'd2);
        n = 0;
        while (!done_m && n < 50) begin cycle(1'b0, '0); n++; end
        check_eq("b2b_done_seen", done_m, 1'b1);
        cycle(1'b1, 8'd3);
        run_idle(100);
        check_eq("b2b_done_pulses", done_cnt - d0, 2);

        // Reset mid-burst with words held in output and skid registers.
        push_cnt += 10; ready_mode = 3;
        cycle(1'b1, 8'd10);
        repeat (4) cycle(1'b0, '0);
        reset_mid();
        ready_mode = 0;
        repeat (3) cycle(1'b0, '0);
        check_eq("post_rst_pops", pop_cnt, burst_ptr);

        // Random traffic with a trickling producer.
        fill_on = 1; ready_mode = 2;
        for (int i = 0; i < 2500; i++)
            cycle(1'($urandom_range(3) == 0), LEN_WIDTH'($urandom_range(40)));
        run_idle(500);

        // Longest burst.
        ready_mode = 0;
        cycle(1'b1, 8'hFF);
        run_idle(2000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter LEN_WIDTH, default 8, meaning burst length field width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: burst request, sampled only in IDLE.
REQ-006 SHALL have port burst_length, input, LEN_WIDTH: number of words to transfer, sampled with start.
REQ-007 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-008 SHALL have port done, output, 1: single-cycle pulse when a burst completes.
REQ-009 SHALL have port fifo_read_enable, output, 1: pop strobe to the show-ahead FIFO read port.
REQ-010 SHALL have port fifo_read_data, input, WIDTH: head word, valid combinationally whenever fifo_empty is low.
REQ-011 SHALL have port fifo_empty, input, 1: FIFO has no readable word.
REQ-012 SHALL have port out_valid, output, 1: out_data/out_last hold a word.
REQ-013 SHALL have port out_ready, input, 1: downstream accepts the word when high with out_valid.
REQ-014 SHALL have port out_data, output, WIDTH: transferred word, registered.
REQ-015 SHALL have port out_last, output, 1: high with the final word of a burst.

Function
REQ-016 States SHALL be IDLE, READ, DRAIN.
REQ-017 IDLE: start with burst_length != 0 SHALL load remaining = burst_length and enter READ; start with burst_length == 0 SHALL pulse done on the next cycle and stay IDLE, with no pop.
REQ-018 start SHALL be ignored while busy.
REQ-019 fifo_read_enable SHALL equal (state == READ) && !fifo_empty && remaining != 0 && skid register empty; no combinational path from out_ready to fifo_read_enable.
REQ-020 Each pop SHALL decrement remaining by 1; the pop taking remaining 1 -> 0 SHALL tag the word last and move READ -> DRAIN.
REQ-021 A popped word SHALL appear on out_data one cycle after the pop if the output register is empty or handshaking that cycle; otherwise it SHALL be captured in the skid register.
REQ-022 Words SHALL leave in FIFO order with no loss or duplication under any out_ready pattern; sustained throughput SHALL be 1 word/cycle with out_ready high and FIFO non-empty.
REQ-023 out_valid SHALL remain high with stable out_data/out_last until handshake.
REQ-024 fifo_empty high mid-burst SHALL stall popping with no state change; popping SHALL resume the cycle fifo_empty falls.
REQ-025 DRAIN: handshake of the last-tagged word SHALL return to IDLE and pulse done for exactly the following cycle.
REQ-026 A start in the cycle done is high SHALL be accepted (back-to-back bursts).
REQ-027 remaining SHALL be LEN_WIDTH bits; burst_length of all ones SHALL transfer 2^LEN_WIDTH-1 words without wrap.

Reset
REQ-028 reset_n low SHALL force, asynchronously: state IDLE, remaining 0, skid and output registers empty, busy 0, done 0, fifo_read_enable 0, out_valid 0, out_data 0, out_last 0.
REQ-029 Reset mid-burst SHALL discard all held words; FIFO contents are outside this block's control.

Structure
REQ-030 The state enum typedef and burst-length width default SHALL live in the shared defines package.
REQ-031 The output register plus skid register SHALL be one sub-module, stream_skid_buffer (WIDTH+1 payload, registered ready-to-upstream).

Verification
REQ-032 Reset: reset_n low mid-burst -> all outputs 0 asynchronously, busy 0 after release, no pop.
REQ-033 FIFO preloaded 0xA0..0xA3, burst_length 4, out_ready 1 -> fifo_read_enable high 4 consecutive cycles, out_data 0xA0..0xA3 one cycle behind, out_last on 0xA3, done one cycle after its handshake.
REQ-034 burst_length 8, out_ready toggling 1,0,1,0 -> 8 words in order, no duplicate, out_data stable while out_ready 0.
REQ-035 burst_length 6, fifo_empty high 5 cycles after word 2 -> fifo_read_enable 0 during gap, 6 words total, busy held.
REQ-036 burst_length 0 -> done one cycle later, fifo_read_enable never high; start during busy -> ignored, remaining unchanged.
REQ-037 Back-to-back: start with length 3 on the done cycle of a length-2 burst -> 5 words total, two done pulses.
